// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in, parallel-out deserializer.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Bit-counter width; floored at 1 so tiny words still get a real counter.
  function automatic int unsigned count_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_deserializer_bit_counter.sv
// Up-counter with synchronous clear and enable, flagging the last bit of a word.
module bit_counter
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CW = count_width(WIDTH);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign tc_c = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_deserializer.sv
// Frames a serial bit stream into WIDTH-bit words and offers them on a
// valid/ready handshake, with frame restart and a sticky overrun flag.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             din,
  input  logic             din_en,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun
);

  state_e           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n, dout_n, shifted_c;
  logic             valid_n, busy_n, overrun_n;
  logic             cnt_clr_c, cnt_en_c, tc_c;

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk  (clk),
    .clr  (clr | cnt_clr_c),
    .en   (cnt_en_c),
    .tc_c (tc_c)
  );

  always_comb begin
    if (MSB_FIRST) begin
      shifted_c = {sreg[WIDTH-2:0], din};
    end else begin
      shifted_c = {din, sreg[WIDTH-1:1]};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    dout_n    = dout;
    valid_n   = dout_valid;
    overrun_n = overrun;
    cnt_clr_c = 1'b0;
    cnt_en_c  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n   = SHIFT;
          sreg_n    = '0;
          cnt_clr_c = 1'b1;
        end
      end
      SHIFT: begin
        if (start) begin
          sreg_n    = '0;
          cnt_clr_c = 1'b1;
        end else if (din_en) begin
          sreg_n = shifted_c;
          if (tc_c) begin
            // Clearing on the final bit keeps the count within WIDTH-1.
            dout_n    = shifted_c;
            valid_n   = 1'b1;
            state_n   = HOLD;
            cnt_clr_c = 1'b1;
          end else begin
            cnt_en_c = 1'b1;
          end
        end
      end
      HOLD: begin
        if (dout_ready) begin
          valid_n = 1'b0;
          if (start) begin
            state_n   = SHIFT;
            sreg_n    = '0;
            cnt_clr_c = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (start) begin
          overrun_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      sreg       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      sreg       <= sreg_n;
      dout       <= dout_n;
      dout_valid <= valid_n;
      busy       <= busy_n;
      overrun    <= overrun_n;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: one MSB-first and one LSB-first instance share
// stimulus; expected words come from a bit-order model of the serial stream.
module tb_sipo_deserializer;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clr, din, din_en, start, dout_ready;
  logic [W-1:0] dout_m, dout_l;
  logic         valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;

  int checks = 0;
  int errors = 0;
  int busy_seen = 0;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .clr(clr), .din(din), .din_en(din_en), .start(start),
    .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
    .busy(busy_m), .overrun(ovr_m)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .clr(clr), .din(din), .din_en(din_en), .start(start),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
    .busy(busy_l), .overrun(ovr_l)
  );

  // ser[7] is the first bit sent; place each serial bit by position and order.
  function automatic logic [W-1:0] model_word(input logic [W-1:0] ser, input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) w[W-1-i] = ser[W-1-i];
      else     w[i]     = ser[W-1-i];
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (busy_m) busy_seen++;
  endtask

  task automatic pulse_start(input logic en_during);
    start  = 1'b1;
    din_en = en_during;
    din    = 1'b1;
    step();
    start  = 1'b0;
    din_en = 1'b0;
  endtask

  // Sends the first n bits of ser with random idle gaps; no word may appear early.
  task automatic send_bits(input logic [W-1:0] ser, input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        din_en = 1'b0;
        din    = 1'($urandom);
        step();
      end
      din_en = 1'b1;
      din    = ser[W-1-i];
      step();
      din_en = 1'b0;
      if (i < n - 1 || n < W) begin
        checks++;
        if ({valid_m, valid_l, busy_m, busy_l} !== 4'b0011) begin
          errors++;
          $display("FAIL mid_frame bit=%0d valid/busy got=%b want=0011", i,
                   {valid_m, valid_l, busy_m, busy_l});
        end
      end
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] ser, input logic ovr);
    checks++;
    if ({dout_m, valid_m, busy_m, ovr_m} !== {model_word(ser, 1'b1), 1'b1, 1'b0, ovr}) begin
      errors++;
      $display("FAIL %s msb got dout=%h v=%b b=%b o=%b want dout=%h v=1 b=0 o=%b", name,
               dout_m, valid_m, busy_m, ovr_m, model_word(ser, 1'b1), ovr);
    end
    checks++;
    if ({dout_l, valid_l, busy_l, ovr_l} !== {model_word(ser, 1'b0), 1'b1, 1'b0, ovr}) begin
      errors++;
      $display("FAIL %s lsb got dout=%h v=%b b=%b o=%b want dout=%h v=1 b=0 o=%b", name,
               dout_l, valid_l, busy_l, ovr_l, model_word(ser, 1'b0), ovr);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) begin
      din        = 1'($urandom);
      din_en     = 1'($urandom);
      start      = 1'($urandom);
      dout_ready = 1'($urandom);
      step();
    end
    checks++;
    if ({dout_m, valid_m, busy_m, ovr_m, dout_l, valid_l, busy_l, ovr_l} !== '0) begin
      errors++;
      $display("FAIL reset got m=%h/%b%b%b l=%h/%b%b%b want all zero",
               dout_m, valid_m, busy_m, ovr_m, dout_l, valid_l, busy_l, ovr_l);
    end
    clr = 1'b0; din = 1'b0; din_en = 1'b0; start = 1'b0; dout_ready = 1'b0;
    step();
  endtask

  task automatic test_msb_lsb_word();
    int busy_start;
    int valid_cycles;
    dout_ready = 1'b1;
    busy_start = busy_seen;
    pulse_start(1'b0);
    send_bits(8'b1011_0010, W, 0);
    checks++;
    if ({dout_m, dout_l} !== {8'hB2, 8'h4D}) begin
      errors++;
      $display("FAIL fixed_word got msb=%h lsb=%h want msb=b2 lsb=4d", dout_m, dout_l);
    end
    check_word("fixed_word", 8'b1011_0010, 1'b0);
    checks++;
    if (busy_seen - busy_start !== W) begin
      errors++;
      $display("FAIL busy_cycles got=%0d want=%0d", busy_seen - busy_start, W);
    end
    valid_cycles = 0;
    repeat (3) begin
      if (valid_m) valid_cycles++;
      step();
    end
    checks++;
    if (valid_cycles !== 1 || valid_m !== 1'b0) begin
      errors++;
      $display("FAIL valid_pulse got cycles=%0d want=1", valid_cycles);
    end
  endtask

  task automatic test_gapped_restart();
    logic [W-1:0] junk;
    junk = W'($urandom);
    dout_ready = 1'b1;
    pulse_start(1'b0);
    send_bits(junk, 5, 3);
    pulse_start(1'b1);
    send_bits(8'hFF, W, 3);
    check_word("restart_ff", 8'hFF, 1'b0);
    step();
  endtask

  task automatic test_back_pressure_overrun();
    logic [W-1:0] w1, w2;
    w1 = W'($urandom);
    w2 = W'($urandom);
    dout_ready = 1'b0;
    pulse_start(1'b0);
    send_bits(w1, W, 1);
    check_word("hold_first", w1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      start = (k == 3);
      step();
      start = 1'b0;
      check_word("hold_window", w1, (k >= 3) ? 1'b1 : 1'b0);
    end
    dout_ready = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l} !== 6'b001111) begin
      errors++;
      $display("FAIL ready_and_start got v/b/o=%b want 001111",
               {valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l});
    end
    send_bits(w2, W, 1);
    check_word("after_overrun", w2, 1'b1);
    step();
  endtask

  task automatic test_mid_frame_clr();
    dout_ready = 1'b1;
    pulse_start(1'b0);
    send_bits(W'($urandom), 4, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if ({dout_m, valid_m, busy_m, ovr_m, dout_l, valid_l, busy_l, ovr_l} !== '0) begin
      errors++;
      $display("FAIL mid_clr got m=%h/%b%b%b l=%h/%b%b%b want all zero",
               dout_m, valid_m, busy_m, ovr_m, dout_l, valid_l, busy_l, ovr_l);
    end
    pulse_start(1'b0);
    send_bits(8'hA5, W, 2);
    check_word("after_clr_a5", 8'hA5, 1'b0);
    step();
  endtask

  task automatic test_random_frames();
    logic [W-1:0] w;
    for (int f = 0; f < 25; f++) begin
      w = W'($urandom);
      dout_ready = 1'b0;
      pulse_start(1'b0);
      send_bits(w, W, 2);
      check_word("random_frame", w, 1'b0);
      repeat ($urandom_range(3, 0)) begin
        step();
        check_word("random_hold", w, 1'b0);
      end
      dout_ready = 1'b1;
      step();
      dout_ready = 1'b0;
      checks++;
      if ({valid_m, valid_l, busy_m, busy_l} !== 4'b0000) begin
        errors++;
        $display("FAIL random_accept got v/b=%b want 0000", {valid_m, valid_l, busy_m, busy_l});
      end
    end
  endtask

  initial begin
    clr = 1'b0; din = 1'b0; din_en = 1'b0; start = 1'b0; dout_ready = 1'b0;
    test_reset();
    test_msb_lsb_word();
    test_gapped_restart();
    test_back_pressure_overrun();
    test_mid_frame_clr();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out capture stage that sits directly downstream of the D flip-flop bit register. It consumes the registered serial bit stream from the flip-flop's `q` output, one bit per enable strobe, and assembles framed words of `WIDTH` bits. Each completed word is presented on a valid/ready handshake to the next stage. It provides start-of-frame restart, back-pressure hold, and a sticky overrun flag.

## Interface
Parameters:
- `WIDTH`, default 8: bits per word; legal range is 2 or more.
- `MSB_FIRST`, default 1: bit order. 1 means the first serial bit lands in `dout[WIDTH-1]`; 0 means it lands in `dout[0]`.

Ports:
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `clr` input, 1 bit: reset, synchronous and active-high.
- `din` input, 1 bit: serial data bit, driven from the upstream flip-flop `q`.
- `din_en` input, 1 bit: `din` is valid this cycle.
- `start` input, 1 bit: frame start pulse.
- `dout` output, `WIDTH` bits: assembled word.
- `dout_valid` output, 1 bit: `dout` holds a complete word.
- `dout_ready` input, 1 bit: downstream accepts the word.
- `busy` output, 1 bit: a frame is in progress (state SHIFT).
- `overrun` output, 1 bit: sticky; a `start` arrived while an unaccepted word was held.

## Operation
- States are IDLE, SHIFT and HOLD.
- IDLE:
  - `din_en` is ignored.
  - On `start`, go to SHIFT and set count to 0.
- SHIFT:
  - Each `din_en` shifts `din` into the shift register and increments count.
  - With `MSB_FIRST`=1 the register shifts left, inserting at bit 0. With `MSB_FIRST`=0 it shifts right, inserting at bit `WIDTH-1`.
  - On the `din_en` with count = `WIDTH-1`: load `dout` with the final word including this bit, set `dout_valid`, and go to HOLD.
  - `start` in SHIFT restarts the frame: count returns to 0, partial bits are discarded, and `din_en` is ignored in that cycle. This is not an overrun.
- HOLD:
  - `dout` and `dout_valid` are stable until `dout_ready`.
  - `dout_ready` alone clears `dout_valid` and returns to IDLE.
  - `dout_ready` and `start` in the same cycle clear `dout_valid` and go straight to SHIFT with count 0. No overrun is raised.
  - `start` without `dout_ready`: stay in HOLD, keep the word, set `overrun`. The start is dropped.
- `dout_ready` has no effect when `dout_valid` is 0.
- `overrun` is cleared only by `clr`.
- Count width is `$clog2(WIDTH)`. Count never exceeds `WIDTH-1`; there is no wrap, because the count is cleared on entry to SHIFT.

## Timing
- On `clr` at an edge:
  - State goes to IDLE; count and the shift register go to 0.
  - Outputs: `dout`=0, `dout_valid`=0, `busy`=0, `overrun`=0.
  - `clr` overrides every other input in the same cycle.
- Asserting `clr` mid-frame or in HOLD discards all data. The outputs take their reset values after that edge.
- Latency:
  - `busy` rises the cycle after the `start` edge.
  - `dout_valid` rises the cycle after the edge that samples the final bit.
  - Minimum frame time is `WIDTH`+1 edges from `start`.
- Handshake:
  - A transfer occurs on an edge where `dout_valid` and `dout_ready` are both 1.
  - `dout_valid` is registered and is never combinationally dependent on `dout_ready`.
- `busy` is 1 exactly while the state is SHIFT.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `sipo_pkg` contains:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2.
  - A count-width function wrapping `$clog2`.
- Sub-module `bit_counter`: a parameterised up-counter with synchronous clear and an enable, plus a terminal-count output at `WIDTH-1`. It is instantiated once.
- The FSM, shift register and output registers live in `sipo_deserializer`.

## Test plan
- Reset:
  - Stimulus: hold `clr`=1 for 3 cycles with random `din`/`din_en`/`start`.
  - Required: `dout`=0, `dout_valid`=0, `busy`=0, `overrun`=0.
- MSB-first word (`WIDTH`=8, `MSB_FIRST`=1):
  - Stimulus: `start`, then bits 1,0,1,1,0,0,1,0 on consecutive `din_en` cycles, with `dout_ready` held 1.
  - Required: `dout`=8'hB2, `dout_valid` high for exactly 1 cycle, `busy` high for 8 cycles.
- LSB-first word (`MSB_FIRST`=0):
  - Stimulus: the same bits as the MSB-first case.
  - Required: `dout`=8'h4D.
- Gapped enables and restart:
  - Stimulus: `din_en` gaps of 0–3 idle cycles; then `start` after 5 bits, followed by 8 new bits 0xFF.
  - Required: `dout`=8'hFF and no `overrun`.
- Back-pressure and overrun:
  - Stimulus: `dout_ready`=0 for 10 cycles after a word, with `start` pulsed in that window.
  - Required: `dout` stable, `overrun`=1 and sticky, state stays in HOLD.
  - Follow-on stimulus: simultaneous `dout_ready` and `start`.
  - Required: the next frame captures without a new `overrun` event.
- Mid-frame `clr`:
  - Stimulus: assert `clr` after 4 bits.
  - Required: all outputs 0 on the next cycle; a following full frame of 8'hA5 captures correctly.
